uart_frame_parser: RTL
======================

Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART byte receiver inside the arm/motor top level.
- Assembles 10-byte command frames of the form 0x55, 0xA5, 7 body bytes, 0xF0.
- Validates header, tail and inter-byte timing.
- Dispatches each good frame as a valid/ready transaction:
  - to the arm UART transmitter, when body byte 0 is 0x00;
  - otherwise to the I2C motor controller.

Parameters:
- TIMEOUT_CYCLES, 200000: maximum Clk cycles allowed between consecutive rx_done strobes inside a frame.
- CNT_W, 24: width of the timeout counter. It must hold TIMEOUT_CYCLES.

Ports:
- Clk  input  1  system clock (50 MHz).
- Rst  input  1  reset, asynchronous, active-high.
- rx_data  input  8  received byte; valid only when rx_done=1.
- rx_done  input  1  one-cycle strobe from the UART receiver.
- arm_frame  output  80  full frame; byte 0 (0x55) in [79:72].
- arm_valid  output  1  arm frame pending.
- arm_ready  input  1  arm transmitter accepts.
- motor_cmd  output  56  body bytes 0..6; body byte 0 in [55:48].
- motor_valid  output  1  motor command pending.
- motor_ready  input  1  motor controller accepts.
- frame_err  output  1  one-cycle pulse on any rejected or aborted frame.
- drop_cnt  output  8  saturating count of good frames dropped because their output was still pending.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; frame buffer, byte index and timeout counter cleared. Reset mid-frame discards the partial frame and any pending output.
- Bytes are consumed only on cycles with rx_done=1.
- State machine:
  - IDLE: byte 0x55 -> HDR2. Any other byte is ignored, with no error.
  - HDR2: 0xA5 -> BODY with idx=0. 0x55 -> stay in HDR2 (resync). Other byte -> IDLE and pulse frame_err.
  - BODY: store the byte at body[idx], then idx++. After the 7th byte (idx=6) -> TAIL.
  - TAIL: 0xF0 -> frame good -> dispatch, then IDLE. Other byte -> IDLE, pulse frame_err.
- Dispatch:
  - Registered. arm_valid or motor_valid rises on the cycle after the rx_done that carried 0xF0.
  - Target is arm if body byte 0 = 0x00, else motor.
  - If the target's valid is already high, the new frame is dropped: drop_cnt++ (saturates at 255). No frame_err, and the pending data is unchanged.
- Valid/ready handshake:
  - Valid stays high and data stays stable until the first cycle with valid&ready.
  - Valid clears on the following edge.
  - Arm and motor channels are independent; both may be pending at once.
  - Ready may be high before valid rises; transfer then completes in the first valid cycle.
- Timeout:
  - The counter runs in HDR2, BODY and TAIL, and clears on every rx_done.
  - When it reaches TIMEOUT_CYCLES: go to IDLE and pulse frame_err.
  - If rx_done and expiry coincide, the byte wins: it is processed and the counter cleared.
  - The counter is held at 0 in IDLE.
- frame_err pulses are one cycle wide. Timeout and bad-byte errors cannot coincide.
- Parsing continues while outputs are pending; there is no backpressure to the UART.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- When defined: body byte 6 must equal the XOR of body bytes 0..5, checked in the TAIL state.
  - Mismatch with a correct tail -> frame rejected, frame_err pulses, nothing dispatched, drop_cnt unchanged.
- When undefined: body byte 6 is plain payload and no check is made.

Test Plan:
1. Arm frame, no macro. Bytes 55 A5 00 00 80 00 00 00 00 F0, arm_ready=1.
   -> arm_valid high for 1 cycle, the cycle after the last rx_done, with arm_frame=0x55A5000080000000 00F0 (80-bit).
   -> motor_valid stays 0; frame_err stays 0.
2. Motor frame, motor_ready=0. Bytes 55 A5 34 04 35 05 06 07 08 F0.
   -> motor_cmd=0x34043505060708 and motor_valid held high.
   -> Raise motor_ready after 50 cycles: valid drops one cycle later.
   -> Repeat the frame while still pending: drop_cnt=1.
3. Errors and resync:
   - Bytes 55 55 A5 34 04 35 05 06 07 08 F0 -> frame accepted (resync).
   - Bytes 55 A5 ... with tail 0x0F -> frame_err pulse, no valid.
   - Bytes 55 12 -> frame_err.
4. Timeout, TIMEOUT_CYCLES=1000:
   - Send 55 A5 34, wait 1000 cycles -> frame_err pulse, state IDLE.
   - Resend a full frame -> accepted.
   - rx_done on exactly cycle 1000 -> byte accepted, no error.
5. FRAME_CHECKSUM_EN defined:
   - Bytes 55 A5 34 04 35 05 06 07 01 F0 (XOR=0x01) -> motor_valid.
   - Same frame with byte 0x08 in that position -> frame_err, no valid.
6. Reset mid-operation:
   - Assert Rst after 5 bytes, with arm_valid pending -> all outputs 0 immediately (async).
   - After release, a full arm frame is dispatched normally.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles 10-byte command frames (55 A5 <7 body> F0)
// from the UART byte receiver and dispatches good frames either to the arm
// transmitter (body byte 0 == 0x00) or to the I2C motor controller.
// Optional build macro FRAME_CHECKSUM_EN: body byte 6 must equal the XOR of
// body bytes 0..5, otherwise the frame is rejected with frame_err.
module uart_frame_parser #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 24
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [79:0] arm_frame,
  output logic        arm_valid,
  input  logic        arm_ready,
  output logic [55:0] motor_cmd,
  output logic        motor_valid,
  input  logic        motor_ready,
  output logic        frame_err,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR2, BODY, TAIL} state_t;

  localparam logic [7:0]       HDR_A   = 8'h55;
  localparam logic [7:0]       HDR_B   = 8'hA5;
  localparam logic [7:0]       TAIL_B  = 8'hF0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [2:0]       idx;
  logic [55:0]      body;     // shifted in MSB-first: body byte 0 ends up in [55:48]
  logic [CNT_W-1:0] tmo_cnt;
  logic             ck_ok;

  // body byte 6 integrity check (tautologically true when the check is built out)
`ifdef FRAME_CHECKSUM_EN
  always_comb begin
    ck_ok = (body[7:0] == (body[55:48] ^ body[47:40] ^ body[39:32] ^
                           body[31:24] ^ body[23:16] ^ body[15:8]));
  end
`else
  always_comb begin
    ck_ok = 1'b1;
  end
`endif

  // frame FSM, timeout counter, output channels and drop counter
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      idx         <= '0;
      body        <= '0;
      tmo_cnt     <= '0;
      arm_frame   <= '0;
      arm_valid   <= 1'b0;
      motor_cmd   <= '0;
      motor_valid <= 1'b0;
      frame_err   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      frame_err <= 1'b0;

      // handshake completes on valid&ready; a dispatch below may re-set valid
      if (arm_valid && arm_ready)     arm_valid   <= 1'b0;
      if (motor_valid && motor_ready) motor_valid <= 1'b0;

      if (state == IDLE) begin
        tmo_cnt <= '0;
        if (rx_done && rx_data == HDR_A) state <= HDR2;
      end else if (rx_done) begin
        // a byte arriving on the expiry cycle wins over the timeout
        tmo_cnt <= '0;
        case (state)
          HDR2: begin
            if (rx_data == HDR_B) begin
              state <= BODY;
              idx   <= '0;
            end else if (rx_data != HDR_A) begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end
          BODY: begin
            body <= {body[47:0], rx_data};
            idx  <= idx + 3'd1;
            if (idx == 3'd6) state <= TAIL;
          end
          TAIL: begin
            state <= IDLE;
            if (rx_data == TAIL_B && ck_ok) begin
              if (body[55:48] == 8'h00) begin
                if (arm_valid) begin
                  if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end else begin
                  arm_valid <= 1'b1;
                  arm_frame <= {HDR_A, HDR_B, body, TAIL_B};
                end
              end else begin
                if (motor_valid) begin
                  if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end else begin
                  motor_valid <= 1'b1;
                  motor_cmd   <= body;
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tmo_cnt == TMO_LAST) begin
        // counter would reach TIMEOUT_CYCLES with no byte: abort the frame
        state     <= IDLE;
        tmo_cnt   <= '0;
        frame_err <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule
